// File: rtl/rom_boot_loader.sv
// rom_boot_loader: owns the instruction ROM write port and the core reset at boot.
// Accepts a little-endian byte stream (32-bit word count, then program words),
// writes the words into the ROM from address 0 upward, and releases the core
// from reset only after the full image has been written.
module rom_boot_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reload,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Largest legal word count: exactly the ROM depth.
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    state_t            state, state_nxt;
    logic [1:0]        byte_idx;
    logic [23:0]       byte_buf;   // first three bytes of the word in flight
    logic [ADDR_W-1:0] word_cnt;   // address of the next word to write
    logic [ADDR_W-1:0] last_idx;   // N-1, address of the final word
    logic              hs;
    logic              word_full;
    logic [31:0]       word;
    logic              len_zero;
    logic              len_over;
    logic              last_word;

    // Bytes are only taken while loading; reload discards a coincident byte.
    assign rx_ready  = (state == S_LEN) || (state == S_DATA);
    assign hs        = rx_valid && rx_ready && !reload;
    assign word_full = hs && (byte_idx == 2'd3);
    assign word      = {rx_data, byte_buf};
    assign len_zero  = (word == 32'd0);
    assign len_over  = ({1'b0, word} > DEPTH);
    // Comparing against N-1 (rather than counting to N) keeps the counter in
    // ADDR_W bits even when N equals the full depth.
    assign last_word = (word_cnt == last_idx);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LEN;
        else        state <= state_nxt;
    end

    // Next-state decode; reload wins over everything.
    always_comb begin
        state_nxt = state;
        if (reload) begin
            state_nxt = S_LEN;
        end else begin
            case (state)
                S_LEN: begin
                    if (word_full) begin
                        if (len_zero)      state_nxt = S_DONE;
                        else if (len_over) state_nxt = S_ERR;
                        else               state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (word_full && last_word) state_nxt = S_DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Byte assembly and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            byte_buf <= 24'd0;
            word_cnt <= '0;
            last_idx <= '0;
        end else if (reload) begin
            byte_idx <= 2'd0;
            word_cnt <= '0;
        end else if (hs) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    byte_buf[7:0]   <= rx_data;
                2'd1:    byte_buf[15:8]  <= rx_data;
                2'd2:    byte_buf[23:16] <= rx_data;
                default: ;
            endcase
            if (word_full) begin
                if (state == S_LEN) begin
                    word_cnt <= '0;
                    last_idx <= ADDR_W'(word - 32'd1);
                end else if (!last_word) begin
                    // Hold on the final word so the counter never wraps to 0.
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    // Registered outputs: write strobe one cycle after the 4th byte, done one
    // cycle after the last write (or right after a zero length), error at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_we     <= 1'b0;
            rom_waddr  <= '0;
            rom_wdata  <= 32'd0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else if (reload) begin
            rom_we     <= 1'b0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            if ((state == S_DATA) && word_full) begin
                rom_we    <= 1'b1;
                rom_waddr <= word_cnt;
                rom_wdata <= word;
            end
            load_done  <= (state == S_DONE) || ((state == S_LEN) && word_full && len_zero);
            core_rst_n <= (state == S_DONE) || ((state == S_LEN) && word_full && len_zero);
            load_err   <= (state == S_ERR)  || ((state == S_LEN) && word_full && len_over);
        end
    end

endmodule
